// File: rtl/tiny_alu.sv
// Multi-cycle 8-bit ALU behind a start/done handshake.
// Add, and and xor execute in one cycle; the unsigned multiply runs through a short pipeline.
module tiny_alu (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [2:0]  op,
  input  logic        start,
  output logic        done,
  output logic [15:0] result
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_REARM = 2'd3;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;
  localparam logic [2:0] OP_RST = 3'd7;

  logic [1:0]  state;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [2:0]  op_q;
  logic [1:0]  cnt;
  logic [11:0] part_lo;
  logic [11:0] part_hi;
  logic [15:0] prod_q;
  logic [15:0] alu_val;

  always_comb begin
    alu_val = 16'h0000;
    case (op_q)
      OP_ADD:  alu_val = 16'(a_q) + 16'(b_q);
      OP_AND:  alu_val = {8'h00, a_q & b_q};
      OP_XOR:  alu_val = {8'h00, a_q ^ b_q};
      OP_MUL:  alu_val = prod_q;
      default: alu_val = 16'h0000;
    endcase
  end

  // The multiply splits B into nibbles: partial products on the first EXEC
  // cycle, their sum on the second, and the result written on the third.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      op_q    <= OP_NOP;
      cnt     <= 2'd0;
      part_lo <= 12'h000;
      part_hi <= 12'h000;
      prod_q  <= 16'h0000;
      done    <= 1'b0;
      result  <= 16'h0000;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (op == OP_ADD || op == OP_AND || op == OP_XOR || op == OP_MUL) begin
              a_q   <= A;
              b_q   <= B;
              op_q  <= op;
              cnt   <= (op == OP_MUL) ? 2'd2 : 2'd0;
              state <= S_EXEC;
            end else if (op == OP_RST) begin
              result <= 16'h0000;
              state  <= S_REARM;
            end
          end
        end
        S_EXEC: begin
          if (cnt == 2'd2) begin
            part_lo <= 12'(a_q) * 12'(b_q[3:0]);
            part_hi <= 12'(a_q) * 12'(b_q[7:4]);
          end
          if (cnt == 2'd1) begin
            prod_q <= 16'(part_lo) + (16'(part_hi) << 4);
          end
          if (cnt == 2'd0) begin
            result <= alu_val;
            done   <= 1'b1;
            state  <= S_DONE;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        S_DONE: begin
          state <= S_REARM;
        end
        S_REARM: begin
          // A start still held from the finished command must not re-trigger it.
          if (!start) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tiny_alu.sv
// Scoreboard bench for tiny_alu: expected results are queued when a command is
// driven and checked, together with the done cycle, when done pulses.
module tb_tiny_alu;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  A = 8'h00;
  logic [7:0]  B = 8'h00;
  logic [2:0]  op = 3'd0;
  logic        start = 1'b0;
  logic        done;
  logic [15:0] result;

  typedef struct {
    string       tag;
    logic [15:0] res;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  tiny_alu dut (
    .clk     (clk),
    .reset_n (reset_n),
    .A       (A),
    .B       (B),
    .op      (op),
    .start   (start),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every done pulse must match the oldest pending command; an empty queue means a spurious done.
  always @(negedge clk) begin
    if (reset_n && done === 1'b1) begin
      if (sb.size() == 0) begin
        check_output("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_output({e.tag, "_result"}, 32'(result), 32'(e.res));
        check_output({e.tag, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
      end
    end
  end

  function automatic logic [15:0] model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    case (o)
      3'd1:    return 16'(a) + 16'(b);
      3'd2:    return {8'h00, a & b};
      3'd3:    return {8'h00, a ^ b};
      3'd4:    return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  task automatic apply_stimulus(input string tag, input logic [2:0] o, input logic [7:0] a,
                                input logic [7:0] b, input bit scramble, input int extra_hold);
    exp_t e;
    int   lat;
    @(posedge clk);
    #1;
    A = a;
    B = b;
    op = o;
    start = 1'b1;
    lat = (o == 3'd4) ? 3 : 1;
    e.tag = tag;
    e.res = model(o, a, b);
    e.cyc = cyc + 1 + lat;
    sb.push_back(e);
    if (scramble) begin
      @(posedge clk);
      #1;
      A = 8'($urandom);
      B = 8'($urandom);
    end
    for (int i = 0; i < 12 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      check_output({tag, "_timeout"}, 32'(sb.size()), 32'd0);
      sb.delete();
    end
    repeat (extra_hold + 1) @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    #12;
    check_output("reset_done", 32'(done), 32'd0);
    check_output("reset_result", 32'(result), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    apply_stimulus("mul_3x5", 3'd4, 8'd3, 8'd5, 1'b0, 1);
    apply_stimulus("add_ff_ff", 3'd1, 8'hFF, 8'hFF, 1'b0, 0);
    apply_stimulus("and_f0_3c", 3'd2, 8'hF0, 8'h3C, 1'b0, 0);
    apply_stimulus("xor_ff_0f", 3'd3, 8'hFF, 8'h0F, 1'b0, 0);
    apply_stimulus("mul_ff_ff", 3'd4, 8'hFF, 8'hFF, 1'b1, 0);

    // Reserved and no-op commands held for ten cycles must leave result alone.
    @(posedge clk);
    #1;
    start = 1'b1;
    op = 3'd0;
    repeat (5) @(posedge clk);
    #1;
    op = 3'd5;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_output("noop_keeps_result", 32'(result), 32'hFE01);

    @(posedge clk);
    #1;
    op = 3'd7;
    @(posedge clk);
    @(negedge clk);
    check_output("rst_op_result", 32'(result), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);

    // Abort a multiply with reset one edge after acceptance; no done may follow.
    #1;
    A = 8'd7;
    B = 8'd9;
    op = 3'd4;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_output("abort_done", 32'(done), 32'd0);
    check_output("abort_result", 32'(result), 32'd0);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (6) @(posedge clk);

    apply_stimulus("add_1_2", 3'd1, 8'd1, 8'd2, 1'b0, 0);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/tiny_alu.md
# tiny_alu

Small multi-cycle arithmetic/logic unit that executes one 8-bit operation per start handshake and returns a 16-bit result. It supports add, and, xor (single-cycle execute) and unsigned multiply (three-cycle execute), plus a no-op and a command reset. It sits behind a simple start/done request interface and is the standard DUT for the block-level verification environment. The requester drives operands, opcode and start, then waits for a one-cycle done pulse.

## Interface
- No parameters; all widths are fixed.
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- A  input  8  operand A, unsigned.
- B  input  8  operand B, unsigned.
- op  input  3  opcode: 0 no_op, 1 add, 2 and, 3 xor, 4 mul, 7 rst_op; 5 and 6 are reserved.
- start  input  1  command request, level-sensitive, held by requester until done.
- done  output  1  one-cycle completion pulse.
- result  output  16  result of the last completed operation.

## Operation
- Every state element resets asynchronously on reset_n low: state IDLE, done 0, result 0x0000, captured operands 0.
- FSM states: IDLE, EXEC, DONE, REARM.
- IDLE: at a rising edge with start=1:
  - op 1–4: capture A, B and op into internal registers, load the cycle counter, and go to EXEC.
  - op 7 (rst_op): clear result to 0, assert no done, and go to REARM.
  - op 0, 5, 6: no action, no done; stay in IDLE.
- Inputs A, B and op are ignored after capture; changing them during EXEC has no effect.
- EXEC: add/and/xor spend 1 cycle, mul spends 3 cycles (multiply pipeline). On the final cycle, write result and go to DONE.
- DONE: done=1 for exactly this one cycle. The next state is REARM.
- REARM: stay until start is sampled 0, then go to IDLE. A held start therefore never re-triggers the same command.
- Arithmetic, all unsigned and zero-extended to 16 bits:
  - add: result = A + B, a 9-bit sum including carry.
  - and: result = {8'h00, A & B}.
  - xor: result = {8'h00, A ^ B}.
  - mul: result = A * B, the full 16-bit product with no truncation.
- result holds its value until the next completed operation or rst_op. It stays valid and stable from the done cycle onward.
- Asserting reset_n low mid-operation aborts the operation immediately: done goes to 0 and result to 0. No done is produced for the aborted command.
- If start drops during EXEC, the operation still completes and pulses done. The FSM then passes through REARM and returns to IDLE on the next edge, because start is already 0.

## Timing
- Define edge N as the rising edge where IDLE samples start=1 with a valid op.
- add/and/xor: result is updated at edge N+1; done is high from N+1 to N+2.
- mul: result is updated at edge N+3; done is high from N+3 to N+4.
- done is registered and is never high for two consecutive cycles.
- The earliest next command is accepted one edge after start is sampled low in REARM.
- rst_op: result reads 0 after edge N. done stays 0.
- Requester contract: hold A, B, op and start from the capture edge until done is seen. Deassert start after done; late deassertion is tolerated by REARM.

## Test plan
- Reset, then mul with A=3, B=5, start held: done pulses at N+3 and result=15. Keep start high for one extra cycle after done: no second done.
- add with A=255, B=255: result=510 (0x01FE) at N+1, with a single done pulse.
- and with A=0xF0, B=0x3C gives 0x0030; xor with A=0xFF, B=0x0F gives 0x00F0. Each has 1-cycle latency, and start is dropped between commands.
- mul with A=255, B=255: result=65025 (0xFE01). Change A and B during EXEC: the result is unchanged.
- no_op and op=5 with start=1 for 10 cycles: done never asserts and result keeps its prior value. Then rst_op: result becomes 0 and no done.
- Start mul with A=7, B=9, then pulse reset_n low at N+1: done and result are 0 immediately and no done follows. A new add with A=1, B=2 after reset gives result=3.
